compare_unit: RTL and testbench
===============================

# compare_unit

Parametrised, registered successor to the 6-bit signed greater-than block in the ALU datapath. It compares two WIDTH-bit operands, signed or unsigned, under eight selectable operations, including MAX/MIN selection and a running-maximum tracker. The result is delivered through a one-entry valid/ready output stage. It sits between the operand registers and the ALU result mux, and also drives the negative-operand LEDs.

## Interface
- WIDTH, 6: operand and result width; ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  unit accepts this cycle.
- a, b  in  WIDTH  operands.
- op  in  3  operation code, one of op_e.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- trk_clr  in  1  empties the tracker; independent of in_valid.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- flag  out  1  boolean outcome (see Operation).
- na_led, nb_led  out  1  sign bit of the last accepted a / b when is_signed, else 0.

## Operation
- Accept when in_valid && in_ready. Capture a, b, op, is_signed and the computed outputs into the output register.
- Compare operands directly; never negate them. Signed order comes from inverting the MSB of both operands and then comparing unsigned. The most-negative value (-2^(WIDTH-1)) therefore orders correctly.
- op_e values and their result/flag:
  - GT=0, LT=1, EQ=2, GE=3, LE=4: flag = the relation; result = flag zero-extended.
  - MAX=5: result = larger operand; flag = 1 if a was selected (a ≥ b).
  - MIN=6: result = smaller operand; flag = 1 if a was selected (a ≤ b).
  - TRACK=7: updates the tracker with a; result = new tracker value; flag = 1 if a replaced the stored value; b is ignored.
- Tracker states:
  - EMPTY → ACTIVE on an accepted TRACK. The first sample loads unconditionally, with flag = 1.
  - ACTIVE: trk_max = max(trk_max, a) under that beat's is_signed. Ties keep the stored value, with flag = 0.
  - ACTIVE → EMPTY on trk_clr.
- trk_clr together with an accepted TRACK in the same cycle: the clear applies first, so the sample is loaded as the first sample.
- trk_clr alone does not affect the output register.
- A non-TRACK op never changes tracker state.
- Output stage: out_valid is set on accept. It is cleared on out_ready unless a new beat is accepted in the same cycle. result, flag and the LEDs stay stable while out_valid && !out_ready.
- in_ready = !out_valid || out_ready (combinational pass-through of out_ready; full throughput).

## Timing
- Latency: 1 cycle. Accept at edge N; out_valid = 1 and result valid after edge N.
- Sustained throughput: 1 beat/cycle while out_ready = 1.
- Reset values (synchronous, at the clk edge with rst_n = 0):
  - out_valid = 0, result = 0, flag = 0, na_led = 0, nb_led = 0.
  - Tracker EMPTY, trk_max = 0.
  - in_ready = 1 in the cycle after reset.
- Reset mid-operation: a held result is discarded and the tracker is emptied. Nothing is accepted in a cycle with rst_n = 0.
- is_signed and op are sampled only on accept. Changes while stalled have no effect.

## Structure
- Package cmp_pkg holds:
  - op_e, a 3-bit enum GT..TRACK;
  - trk_state_e, with EMPTY and ACTIVE;
  - the function sext_msb_flip, which prepares operands for the signed compare.
- Sub-module cmp_core: combinational, parametrised by WIDTH. Inputs x, y, is_signed; outputs lt and eq. It is instantiated twice: once for a vs b, once for a vs trk_max.
- compare_unit holds the tracker, the output register and the handshake.

## Test plan
- WIDTH=6, op=GT, a=6'h3F, b=6'h01:
  - is_signed=1 → result=0, flag=0, na_led=1, nb_led=0.
  - is_signed=0 → result=1, flag=1, na_led=0, nb_led=0.
- Extremes, signed: a=6'h20 (-32), b=6'h1F (31). LT → flag=1; MIN → result=6'h20, flag=1; MAX → result=6'h1F, flag=0. EQ with a=b=6'h20 → flag=1.
- Backpressure: accept MAX a=9, b=4, then hold out_ready=0 for 3 cycles with in_valid=1 and a new beat presented. Required: result stays 9, in_ready=0. When out_ready rises, the new beat is accepted in that same cycle and appears on the next cycle.
- Tracker, signed TRACK stream 5, -3, 12, 12:
  - results 5, 5, 12, 12; flags 1, 0, 1, 0.
  - Then trk_clr=1 with an accepted TRACK of -7 in the same cycle → result -7 (6'h39), flag=1.
- Reset: with out_valid=1 and the tracker holding 12, drive rst_n=0 for one edge. Required: out_valid=0, result=0, LEDs 0. A following TRACK of -2 yields result -2, flag=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the compare unit.
package cmp_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        GT    = 3'd0,
        LT    = 3'd1,
        EQ    = 3'd2,
        GE    = 3'd3,
        LE    = 3'd4,
        MAX   = 3'd5,
        MIN   = 3'd6,
        TRACK = 3'd7
    } op_e;

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } trk_state_e;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the most-negative value needs no special case.
    function automatic logic [MAX_W-1:0] sext_msb_flip(input logic [MAX_W-1:0] v,
                                                       input int w,
                                                       input logic sgn);
        logic [MAX_W-1:0] m;
        m        = '0;
        m[w-1]   = sgn;
        return v ^ m;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude/equality compare, signed or unsigned.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             is_signed,
    output logic             lt,
    output logic             eq
);

    logic [MAX_W-1:0] xf;
    logic [MAX_W-1:0] yf;

    assign xf = sext_msb_flip(MAX_W'(x), WIDTH, is_signed);
    assign yf = sext_msb_flip(MAX_W'(y), WIDTH, is_signed);
    assign lt = xf < yf;
    assign eq = x == y;

endmodule

// File: rtl/compare_unit.sv
// Registered compare unit: eight compare/select ops, running-max tracker,
// one-entry valid/ready output stage.
module compare_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             is_signed,
    input  logic             trk_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             na_led,
    output logic             nb_led
);

    logic             lt_ab, eq_ab, lt_at, eq_at;
    logic             accept, trk_empty, trk_replace, flag_c;
    logic [WIDTH-1:0] res_c;

    trk_state_e       trk_state_q, trk_state_d;
    logic [WIDTH-1:0] trk_max_q, trk_max_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic             na_q, na_d, nb_q, nb_d;

    cmp_core #(.WIDTH(WIDTH)) u_cmp_ab (
        .x(a), .y(b), .is_signed(is_signed), .lt(lt_ab), .eq(eq_ab)
    );

    cmp_core #(.WIDTH(WIDTH)) u_cmp_trk (
        .x(a), .y(trk_max_q), .is_signed(is_signed), .lt(lt_at), .eq(eq_at)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        flag_c      = 1'b0;
        res_c       = '0;
        // A same-cycle clear takes effect before the sample is considered.
        trk_empty   = trk_clr || (trk_state_q == EMPTY);
        trk_replace = trk_empty || !(lt_at || eq_at);
        case (op_e'(op))
            GT:    flag_c = !lt_ab && !eq_ab;
            LT:    flag_c = lt_ab;
            EQ:    flag_c = eq_ab;
            GE:    flag_c = !lt_ab;
            LE:    flag_c = lt_ab || eq_ab;
            MAX: begin
                flag_c = !lt_ab;
                res_c  = flag_c ? a : b;
            end
            MIN: begin
                flag_c = lt_ab || eq_ab;
                res_c  = flag_c ? a : b;
            end
            TRACK: begin
                flag_c = trk_replace;
                res_c  = trk_replace ? a : trk_max_q;
            end
            default: ;
        endcase
        if (op_e'(op) < MAX) res_c = {{(WIDTH-1){1'b0}}, flag_c};
    end

    always_comb begin
        trk_state_d = trk_state_q;
        trk_max_d   = trk_max_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_d      = flag_q;
        na_d        = na_q;
        nb_d        = nb_q;
        if (trk_clr) begin
            trk_state_d = EMPTY;
            trk_max_d   = '0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = res_c;
            flag_d      = flag_c;
            na_d        = is_signed && a[WIDTH-1];
            nb_d        = is_signed && b[WIDTH-1];
            if (op_e'(op) == TRACK) begin
                trk_state_d = ACTIVE;
                trk_max_d   = res_c;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trk_state_q <= EMPTY;
            trk_max_q   <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            na_q        <= 1'b0;
            nb_q        <= 1'b0;
        end else begin
            trk_state_q <= trk_state_d;
            trk_max_q   <= trk_max_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_q      <= flag_d;
            na_q        <= na_d;
            nb_q        <= nb_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag      = flag_q;
    assign na_led    = na_q;
    assign nb_led    = nb_q;

endmodule

// File: tb/tb_compare_unit.sv
// Self-checking bench for compare_unit: directed table, corner sequences,
// and random traffic against an integer-arithmetic reference model.
module tb_compare_unit;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, is_signed, trk_clr;
    logic         out_valid, out_ready, flag, na_led, nb_led;
    logic [W-1:0] a, b, result;
    logic [2:0]   op;

    compare_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .is_signed(is_signed), .trk_clr(trk_clr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag(flag), .na_led(na_led), .nb_led(nb_led)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit         m_has;
    logic [W-1:0] m_max;
    bit         e_valid, e_flag, e_na, e_nb;
    logic [W-1:0] e_res;

    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0]   op;
        bit           sgn;
        logic [W-1:0] res;
        bit           flg, na, nb;
    } vec_t;

    vec_t tbl[8];

    function automatic int val(input logic [W-1:0] x, input bit s);
        return (s && x[W-1]) ? int'(x) - (1 << W) : int'(x);
    endfunction

    task automatic model_beat(input logic [W-1:0] ai, bi, input logic [2:0] oi, input bit s);
        int av, bv;
        bit f;
        logic [W-1:0] r;
        av = val(ai, s);
        bv = val(bi, s);
        f  = 1'b0;
        r  = '0;
        case (oi)
            3'd0: f = av > bv;
            3'd1: f = av < bv;
            3'd2: f = av == bv;
            3'd3: f = av >= bv;
            3'd4: f = av <= bv;
            3'd5: begin f = av >= bv; r = f ? ai : bi; end
            3'd6: begin f = av <= bv; r = f ? ai : bi; end
            default: begin
                f = !m_has || av > val(m_max, s);
                r = f ? ai : m_max;
                m_has = 1'b1;
                m_max = r;
            end
        endcase
        if (oi < 3'd5) r = {{(W-1){1'b0}}, f};
        e_valid = 1'b1;
        e_res   = r;
        e_flag  = f;
        e_na    = s && ai[W-1];
        e_nb    = s && bi[W-1];
    endtask

    // One clock: drive at negedge, update model, sample 1 after posedge.
    task automatic cyc(input bit iv, input logic [W-1:0] ai, bi, input logic [2:0] oi,
                       input bit s, input bit clr, input bit ordy);
        bit acc;
        @(negedge clk);
        in_valid = iv; a = ai; b = bi; op = oi; is_signed = s;
        trk_clr = clr; out_ready = ordy;
        acc = iv && (!e_valid || ordy);
        if (clr) begin m_has = 1'b0; m_max = '0; end
        if (acc) model_beat(ai, bi, oi, s);
        else if (ordy) e_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; trk_clr = 1'b0;
        @(posedge clk);
        #1;
        e_valid = 0; e_res = '0; e_flag = 0; e_na = 0; e_nb = 0;
        m_has = 0; m_max = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk(input string nm, input bit v, input logic [W-1:0] r,
                       input bit f, input bit na, input bit nb);
        vectors++;
        if (out_valid !== v || result !== r || flag !== f || na_led !== na || nb_led !== nb) begin
            miscompares++;
            $display("FAIL %s: got v=%0b r=%h f=%0b na=%0b nb=%0b, want v=%0b r=%h f=%0b na=%0b nb=%0b",
                     nm, out_valid, result, flag, na_led, nb_led, v, r, f, na, nb);
        end
    endtask

    task automatic chk_model(input string nm);
        chk(nm, e_valid, e_res, e_flag, e_na, e_nb);
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0b want %0b", nm, got, want);
        end
    endtask

    initial begin
        tbl[0] = '{6'h3F, 6'h01, 3'd0, 1'b1, 6'h00, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{6'h3F, 6'h01, 3'd0, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{6'h20, 6'h1F, 3'd1, 1'b1, 6'h01, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{6'h20, 6'h1F, 3'd6, 1'b1, 6'h20, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{6'h20, 6'h1F, 3'd5, 1'b1, 6'h1F, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{6'h20, 6'h20, 3'd2, 1'b1, 6'h01, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{6'h05, 6'h05, 3'd3, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{6'h01, 6'h3F, 3'd4, 1'b1, 6'h00, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 0; a = '0; b = '0; op = '0;
        is_signed = 0; trk_clr = 0; out_ready = 1;
        m_has = 0; m_max = '0; e_valid = 0; e_res = '0; e_flag = 0; e_na = 0; e_nb = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 0, 6'h00, 0, 0, 0);
        chk_bit("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cyc(1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].sgn, 0, 1);
            chk($sformatf("table[%0d]", i), 1, tbl[i].res, tbl[i].flg, tbl[i].na, tbl[i].nb);
        end

        // signed tracker stream 5, -3, 12, 12, then clear + TRACK -7
        cyc(1, 6'd5,  6'h00, 3'd7, 1, 0, 1); chk("trk_5",   1, 6'd5,  1, 0, 0);
        cyc(1, 6'h3D, 6'h00, 3'd7, 1, 0, 1); chk("trk_m3",  1, 6'd5,  0, 1, 0);
        cyc(1, 6'd12, 6'h00, 3'd7, 1, 0, 1); chk("trk_12",  1, 6'd12, 1, 0, 0);
        cyc(1, 6'd12, 6'h00, 3'd7, 1, 0, 1); chk("trk_12b", 1, 6'd12, 0, 0, 0);
        cyc(1, 6'h39, 6'h00, 3'd7, 1, 1, 1); chk("trk_clr_m7", 1, 6'h39, 1, 1, 0);

        // backpressure: held MAX result, stalled new beat with changing attrs
        cyc(1, 6'd9, 6'd4, 3'd5, 0, 0, 1); chk("bp_max", 1, 6'd9, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 6'd1, 6'd2, (i == 1) ? 3'd3 : 3'd0, i[0], 0, 0);
            chk($sformatf("bp_hold%0d", i), 1, 6'd9, 1, 0, 0);
            chk_bit($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
        end
        @(negedge clk);
        op = 3'd0; is_signed = 0; out_ready = 1;
        #1;
        chk_bit("bp_ready_pass", in_ready, 1'b1);
        cyc(1, 6'd1, 6'd2, 3'd0, 0, 0, 1); chk("bp_release", 1, 6'd0, 0, 0, 0);

        // reset while holding a result and tracker holds 12
        cyc(1, 6'd12, 6'h00, 3'd7, 1, 0, 1); chk("rst_pre_trk", 1, 6'd12, 1, 0, 0);
        cyc(0, 6'h00, 6'h00, 3'd0, 0, 0, 0); chk("rst_pre_hold", 1, 6'd12, 1, 0, 0);
        do_reset();
        chk("rst_mid", 0, 6'h00, 0, 0, 0);
        cyc(1, 6'h3E, 6'h00, 3'd7, 1, 0, 1); chk("rst_trk_m2", 1, 6'h3E, 1, 1, 0);

        // random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 3'($urandom),
                1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            chk_model($sformatf("rand[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
